// File: rtl/button_pkg.sv
// Shared types and constants for the two-player button conditioner.
package button_pkg;

  // Debounce counter width; wide enough for any legal DEBOUNCE_CYCLES.
  localparam int unsigned DBNC_CNT_W = 16;

  // Per-channel debounce state.
  typedef enum logic [1:0] {
    STABLE_LO  = 2'd0,
    CONFIRM_HI = 2'd1,
    STABLE_HI  = 2'd2,
    CONFIRM_LO = 2'd3
  } dbnc_state_t;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchronizer, debounce FSM with counter,
// and registered press/release pulses. o_press_next is the value the
// press pulse register loads on the coming edge. The top uses it so that
// its tie register pulses in the same cycle as the press pulses.
module btn_debounce_ch
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_press_next
);

  // Count value that completes a confirmation on the current edge.
  localparam logic [DBNC_CNT_W-1:0] CNT_LAST = DBNC_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DBNC_CNT_W-1:0] CNT_ONE  = DBNC_CNT_W'(1);

  logic                  r_sync1;
  logic                  r_sync2;
  dbnc_state_t           r_state;
  dbnc_state_t           w_state_nxt;
  logic [DBNC_CNT_W-1:0] r_cnt;
  logic [DBNC_CNT_W-1:0] w_cnt_nxt;
  logic                  r_level;
  logic                  w_level_nxt;
  logic                  r_press;
  logic                  w_press_nxt;
  logic                  r_release;
  logic                  w_release_nxt;

  // Bring the asynchronous pin into the clock domain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // FSM state, counter, level and pulse registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= STABLE_LO;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_level   <= w_level_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
    end
  end

  // Next-state logic; the counter saturates at CNT_LAST by construction.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_level_nxt   = r_level;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    case (r_state)
      STABLE_LO: begin
        if (r_sync2) begin
          w_state_nxt = CONFIRM_HI;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      CONFIRM_HI: begin
        if (!r_sync2) begin
          w_state_nxt = STABLE_LO;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = STABLE_HI;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b1;
          w_press_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!r_sync2) begin
          w_state_nxt = CONFIRM_LO;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      CONFIRM_LO: begin
        if (r_sync2) begin
          w_state_nxt = STABLE_HI;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt   = STABLE_LO;
          w_cnt_nxt     = '0;
          w_level_nxt   = 1'b0;
          w_release_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = STABLE_LO;
        w_cnt_nxt   = '0;
        w_level_nxt = 1'b0;
      end
    endcase
  end

  assign o_level      = r_level;
  assign o_press      = r_press;
  assign o_release    = r_release;
  assign o_press_next = w_press_nxt;

endmodule

// File: rtl/button_conditioner.sv
// Debounces both player buttons and flags simultaneous presses (tie).
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CLOCK_FREQ      = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn1_raw,
  input  logic btn2_raw,
  output logic btn1,
  output logic btn2,
  output logic btn1_press,
  output logic btn2_press,
  output logic btn1_release,
  output logic btn2_release,
  output logic tie
);

  // Reject parameter values outside the supported range at elaboration.
  if (CLOCK_FREQ < 1 || DEBOUNCE_CYCLES < 2 ||
      DEBOUNCE_CYCLES > ((1 << DBNC_CNT_W) - 1)) begin : g_bad_params
    $error("button_conditioner: illegal DEBOUNCE_CYCLES or CLOCK_FREQ");
  end

  logic w_press1_nxt;
  logic w_press2_nxt;
  logic r_tie;

  btn_debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_ch1 (
    .i_clk        (clk),
    .i_rst_n      (reset),
    .i_raw        (btn1_raw),
    .o_level      (btn1),
    .o_press      (btn1_press),
    .o_release    (btn1_release),
    .o_press_next (w_press1_nxt)
  );

  btn_debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_ch2 (
    .i_clk        (clk),
    .i_rst_n      (reset),
    .i_raw        (btn2_raw),
    .o_level      (btn2),
    .o_press      (btn2_press),
    .o_release    (btn2_release),
    .o_press_next (w_press2_nxt)
  );

  // Tie is registered alongside the press pulses it combines.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_tie <= 1'b0;
    else        r_tie <= w_press1_nxt & w_press2_nxt;
  end

  assign tie = r_tie;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES = 4.
// Outputs are compared as {btn1, btn2, btn1_press, btn2_press,
// btn1_release, btn2_release, tie}, sampled 1 time unit after each edge.
module tb_button_conditioner;

  logic clk;
  logic reset;
  logic btn1_raw;
  logic btn2_raw;
  logic btn1, btn2, btn1_press, btn2_press, btn1_release, btn2_release, tie;

  int n_checks = 0;
  int n_fail   = 0;

  button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CLOCK_FREQ     (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn1_raw     (btn1_raw),
    .btn2_raw     (btn2_raw),
    .btn1         (btn1),
    .btn2         (btn2),
    .btn1_press   (btn1_press),
    .btn2_press   (btn2_press),
    .btn1_release (btn1_release),
    .btn2_release (btn2_release),
    .tie          (tie)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = {btn1, btn2, btn1_press, btn2_press, btn1_release, btn2_release, tie};
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    reset    = 1'b0;
    btn1_raw = 1'b0;
    btn2_raw = 1'b0;

    // Reset state, before and after clock edges.
    #2 chk("reset_no_clk", 7'b0000000);
    ticks(3);
    chk("reset_held", 7'b0000000);
    reset = 1'b1;
    ticks(3);
    chk("idle", 7'b0000000);

    // Clean press of btn1: sampled at edge k, level at k+5.
    btn1_raw = 1'b1;
    tick();                      // k
    ticks(3);                    // k+3
    chk("p1_k3", 7'b0000000);
    tick();                      // k+4
    chk("p1_k4", 7'b0000000);
    tick();                      // k+5
    chk("p1_press", 7'b1010000);
    tick();
    chk("p1_after", 7'b1000000);
    ticks(2);
    chk("p1_hold", 7'b1000000);

    // Clean release of btn1.
    btn1_raw = 1'b0;
    tick();                      // k
    ticks(4);                    // k+4
    chk("r1_k4", 7'b1000000);
    tick();                      // k+5
    chk("r1_release", 7'b0000100);
    tick();
    chk("r1_after", 7'b0000000);

    // Bouncing btn2, then held: exactly one press 5 edges after hold.
    for (int i = 0; i < 6; i++) begin
      btn2_raw = (i % 2 == 0);
      tick();
      chk("b2_bounce", 7'b0000000);
    end
    btn2_raw = 1'b1;
    tick();                      // h
    ticks(3);                    // h+3
    chk("b2_h3", 7'b0000000);
    tick();                      // h+4
    chk("b2_h4", 7'b0000000);
    tick();                      // h+5
    chk("b2_press", 7'b0101000);
    tick();
    chk("b2_after", 7'b0100000);
    btn2_raw = 1'b0;
    tick();
    ticks(4);
    chk("r2_k4", 7'b0100000);
    tick();
    chk("r2_release", 7'b0000010);
    tick();
    chk("r2_after", 7'b0000000);

    // Simultaneous press: tie pulses with both presses.
    btn1_raw = 1'b1;
    btn2_raw = 1'b1;
    tick();
    ticks(4);
    chk("tie_k4", 7'b0000000);
    tick();
    chk("tie_pulse", 7'b1111001);
    tick();
    chk("tie_after", 7'b1100000);
    btn1_raw = 1'b0;
    btn2_raw = 1'b0;
    tick();
    ticks(4);
    chk("rel_both_k4", 7'b1100000);
    tick();
    chk("rel_both", 7'b0000110);
    tick();
    chk("rel_both_after", 7'b0000000);

    // 3-cycle glitch on btn1 is filtered.
    btn1_raw = 1'b1;
    ticks(3);
    btn1_raw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("glitch3", 7'b0000000);
    end

    // 4-cycle pulse is the shortest accepted press.
    btn1_raw = 1'b1;
    ticks(4);                    // k..k+3
    btn1_raw = 1'b0;
    tick();                      // k+4
    chk("p4_k4", 7'b0000000);
    tick();                      // k+5
    chk("p4_press", 7'b1010000);
    tick();                      // k+6
    chk("p4_k6", 7'b1000000);
    ticks(2);                    // k+8
    chk("p4_k8", 7'b1000000);
    tick();                      // k+9
    chk("p4_release", 7'b0000100);
    tick();
    chk("p4_after", 7'b0000000);

    // Reset two cycles into CONFIRM_HI discards the partial count.
    btn1_raw = 1'b1;
    ticks(4);                    // k..k+3, count at 2
    reset = 1'b0;
    #1 chk("rst_confirm", 7'b0000000);
    ticks(2);
    chk("rst_confirm_held", 7'b0000000);
    reset = 1'b1;
    tick();                      // r
    ticks(3);                    // r+3
    chk("rst_r3", 7'b0000000);
    tick();                      // r+4
    chk("rst_r4", 7'b0000000);
    tick();                      // r+5
    chk("rst_press", 7'b1010000);
    tick();
    chk("rst_after", 7'b1000000);

    // Reset with btn1 level high clears outputs without a clock edge.
    reset = 1'b0;
    #1 chk("rst_level_async", 7'b0000000);
    tick();
    chk("rst_level_held", 7'b0000000);
    reset = 1'b1;
    tick();                      // r
    ticks(3);                    // r+3
    chk("rel_r3", 7'b0000000);
    tick();                      // r+4
    chk("rel_r4", 7'b0000000);
    tick();                      // r+5
    chk("rel_press", 7'b1010000);
    tick();
    chk("rel_after", 7'b1000000);

    btn1_raw = 1'b0;
    tick();
    ticks(4);
    chk("final_k4", 7'b1000000);
    tick();
    chk("final_release", 7'b0000100);
    tick();
    chk("final_idle", 7'b0000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
